alu_issue_stage: RTL and testbench

//  Decode/issue stage directly upstream of the SIC-4 8-bit ALU. Accepts 16-bit

---
 rtl/alu_issue_stage_pkg.sv | 51 +++++
 rtl/sic4_regfile.sv | 34 +++
 rtl/alu_issue_stage.sv | 102 ++++++++++
 tb/tb_alu_issue_stage.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_stage_pkg.sv
// rtl/alu_issue_stage_pkg.sv - SIC-4 issue stage shared defs: fields, opcodes, ALU ops, FSM states
package alu_issue_stage_pkg;

    localparam int NREGS   = 4;
    localparam int DW      = 8;
    localparam int RA_W    = 2;
    localparam int INSTR_W = 16;

    localparam int OP_HI  = 15;
    localparam int OP_LO  = 13;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 10;
    localparam int RS1_HI = 9;
    localparam int RS1_LO = 8;
    localparam int RS2_HI = 7;
    localparam int RS2_LO = 6;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_SHIFT = 3'b010,
        OP_AND   = 3'b011,
        OP_LDI   = 3'b100,
        OP_NOP   = 3'b101,
        OP_ILL0  = 3'b110,
        OP_ILL1  = 3'b111
    } opcode_e;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_SHIFT = 2'b10;
    localparam logic [1:0] ALUOP_AND   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_WB   = 2'b10
    } state_e;

    function automatic logic [1:0] aluop_of(input opcode_e op);
        case (op)
            OP_SUB:   return ALUOP_SUB;
            OP_SHIFT: return ALUOP_SHIFT;
            OP_AND:   return ALUOP_AND;
            default:  return ALUOP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/sic4_regfile.sv
// rtl/sic4_regfile.sv - NREGSxDW register file: two async reads, debug read, one sync write, async clear
module sic4_regfile #(
    parameter int NREGS = alu_issue_stage_pkg::NREGS,
    parameter int DW    = alu_issue_stage_pkg::DW,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr1,
    output logic [DW-1:0] rdata1,
    input  logic [AW-1:0] raddr2,
    output logic [DW-1:0] rdata2,
    input  logic [AW-1:0] dbg_raddr,
    output logic [DW-1:0] dbg_rdata
);

    logic [DW-1:0] rf [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (we) begin
            rf[waddr] <= wdata;
        end
    end

    assign rdata1    = rf[raddr1];
    assign rdata2    = rf[raddr2];
    assign dbg_rdata = rf[dbg_raddr];

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - SIC-4 decode/issue stage around the 8-bit ALU; ALU_FLAGS_EN adds zero_flag
module alu_issue_stage
    import alu_issue_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    output logic [DW-1:0]      alu_a,
    output logic [DW-1:0]      alu_b,
    output logic [1:0]         alu_aluop,
    input  logic [DW-1:0]      alu_res,
    output logic               wb_valid,
    input  logic               wb_ready,
    output logic [RA_W-1:0]    wb_rd,
    output logic [DW-1:0]      wb_data,
    output logic               illegal,
    input  logic [RA_W-1:0]    dbg_raddr,
    output logic [DW-1:0]      dbg_rdata
`ifdef ALU_FLAGS_EN
    ,
    output logic               zero_flag
`endif
);

    state_e          state;
    opcode_e         op;
    logic [DW-1:0]   rs1_data;
    logic [DW-1:0]   rs2_data;
    logic            wb_fire;
    logic            unused_bit;

    assign op         = opcode_e'(in_instr[OP_HI:OP_LO]);
    assign unused_bit = in_instr[12];
    assign in_ready   = (state == ST_IDLE);
    assign wb_valid   = (state == ST_WB);
    assign wb_fire    = (state == ST_WB) && wb_ready;

    sic4_regfile #(.NREGS(NREGS), .DW(DW), .AW(RA_W)) u_rf (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (wb_fire),
        .waddr     (wb_rd),
        .wdata     (wb_data),
        .raddr1    (in_instr[RS1_HI:RS1_LO]),
        .rdata1    (rs1_data),
        .raddr2    (in_instr[RS2_HI:RS2_LO]),
        .rdata2    (rs2_data),
        .dbg_raddr (dbg_raddr),
        .dbg_rdata (dbg_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_aluop <= ALUOP_ADD;
            wb_rd     <= '0;
            wb_data   <= '0;
            illegal   <= 1'b0;
        end else begin
            illegal <= 1'b0;
            case (state)
                ST_IDLE: if (in_valid) begin
                    case (op)
                        OP_ADD, OP_SUB, OP_SHIFT, OP_AND: begin
                            alu_a     <= rs1_data;
                            alu_b     <= rs2_data;
                            alu_aluop <= aluop_of(op);
                            wb_rd     <= in_instr[RD_HI:RD_LO];
                            state     <= ST_EXEC;
                        end
                        OP_LDI: begin
                            wb_data <= in_instr[IMM_HI:IMM_LO];
                            wb_rd   <= in_instr[RD_HI:RD_LO];
                            state   <= ST_WB;
                        end
                        OP_NOP:  ;
                        default: illegal <= 1'b1;
                    endcase
                end
                ST_EXEC: begin
                    wb_data <= alu_res;
                    state   <= ST_WB;
                end
                ST_WB: if (wb_ready) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ALU_FLAGS_EN
    // Tracks the value most recently committed to the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       zero_flag <= 1'b0;
        else if (wb_fire) zero_flag <= (wb_data == '0);
    end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - scoreboard bench for alu_issue_stage
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_instr = 16'h0;
    logic [7:0]  alu_a, alu_b, alu_res;
    logic [1:0]  alu_aluop;
    logic        wb_valid;
    logic        wb_ready = 1'b1;
    logic [1:0]  wb_rd;
    logic [7:0]  wb_data;
    logic        illegal;
    logic [1:0]  dbg_raddr = 2'd0;
    logic [7:0]  dbg_rdata;
`ifdef ALU_FLAGS_EN
    logic        zero_flag;
`endif

    int checks = 0;
    int failures = 0;
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    always_comb begin
        case (alu_aluop)
            2'b00:   alu_res = alu_a + alu_b;
            2'b01:   alu_res = alu_a - alu_b;
            2'b10:   alu_res = alu_a << alu_b[2:0];
            default: alu_res = alu_a & alu_b;
        endcase
    end

    alu_issue_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .alu_a(alu_a), .alu_b(alu_b), .alu_aluop(alu_aluop),
        .alu_res(alu_res), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
        .wb_data(wb_data), .illegal(illegal), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
`ifdef ALU_FLAGS_EN
        , .zero_flag(zero_flag)
`endif
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every writeback handshake is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && wb_valid && wb_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL wb_unexpected: got rd=%0d data=%h expected none", wb_rd, wb_data);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                if ({wb_rd, wb_data} !== e) begin
                    failures++;
                    $display("FAIL wb_result: got rd=%0d data=%h expected rd=%0d data=%h",
                             wb_rd, wb_data, e[9:8], e[7:0]);
                end
            end
        end
    end

    task automatic dbg(input logic [1:0] r, input logic [7:0] exp, input string name);
        dbg_raddr = r;
        #1;
        check(name, {8'h0, dbg_rdata}, {8'h0, exp});
    endtask

    task automatic issue(input logic [15:0] instr);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_instr = instr;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(in_ready && !wb_valid) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got busy expected idle", name);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {15'h0, in_ready}, 16'h1);
        check("rst_wb_valid", {15'h0, wb_valid}, 16'h0);
        check("rst_alu_a", {8'h0, alu_a}, 16'h0);
        check("rst_aluop", {14'h0, alu_aluop}, 16'h0);
        check("rst_wb_data", {8'h0, wb_data}, 16'h0);
        rst_n = 1'b1;
        #1;
        check("rst_rel_in_ready", {15'h0, in_ready}, 16'h1);
        for (int i = 0; i < 4; i++) dbg(i[1:0], 8'h00, "rst_rf");

        exp_q.push_back({2'd1, 8'h05});
        issue(16'h8405);
        check("ldi_wb_valid_n1", {15'h0, wb_valid}, 16'h1);
        check("ldi_in_ready_low", {15'h0, in_ready}, 16'h0);
        wait_idle("ldi1");
        exp_q.push_back({2'd2, 8'h03});
        issue(16'h8803);
        wait_idle("ldi2");
        dbg(2'd1, 8'h05, "ldi_r1");
        dbg(2'd2, 8'h03, "ldi_r2");

        exp_q.push_back({2'd3, 8'h08});
        issue(16'h0D80);
        check("add_exec_a", {8'h0, alu_a}, 16'h0005);
        check("add_exec_b", {8'h0, alu_b}, 16'h0003);
        check("add_exec_op", {14'h0, alu_aluop}, 16'h0);
        check("add_exec_wb_valid", {15'h0, wb_valid}, 16'h0);
        check("add_exec_in_ready", {15'h0, in_ready}, 16'h0);
        @(posedge clk); #1;
        check("add_wb_valid", {15'h0, wb_valid}, 16'h1);
        wait_idle("add");

        exp_q.push_back({2'd0, 8'h02});
        issue(16'h2180);
        check("sub_exec_op", {14'h0, alu_aluop}, 16'h1);
        check("sub_in_ready_exec", {15'h0, in_ready}, 16'h0);
        @(posedge clk); #1;
        check("sub_in_ready_wb", {15'h0, in_ready}, 16'h0);
        wait_idle("sub");

        exp_q.push_back({2'd1, 8'h00});
        issue(16'h6780);
        check("and_exec_op", {14'h0, alu_aluop}, 16'h3);
        wait_idle("and");
        exp_q.push_back({2'd2, 8'h20});
        issue(16'h4B00);
        check("shift_fwd_b", {8'h0, alu_b}, 16'h0002);
        wait_idle("shift");

        issue(16'hC000);
        check("ill_pulse", {15'h0, illegal}, 16'h1);
        check("ill_in_ready", {15'h0, in_ready}, 16'h1);
        @(posedge clk); #1;
        check("ill_pulse_end", {15'h0, illegal}, 16'h0);
        dbg(2'd0, 8'h02, "ill_r0");
        dbg(2'd1, 8'h00, "ill_r1");
        dbg(2'd2, 8'h20, "ill_r2");
        dbg(2'd3, 8'h08, "ill_r3");

        issue(16'hA000);
        check("nop_in_ready", {15'h0, in_ready}, 16'h1);
        check("nop_wb_valid", {15'h0, wb_valid}, 16'h0);

        wb_ready = 1'b0;
        exp_q.push_back({2'd3, 8'h77});
        issue(16'h8C77);
        for (int i = 0; i < 3; i++) begin
            check("hold_wb_valid", {15'h0, wb_valid}, 16'h1);
            check("hold_wb_data", {8'h0, wb_data}, 16'h0077);
            dbg(2'd3, 8'h08, "hold_no_write");
            @(posedge clk); #1;
        end
        wb_ready = 1'b1;
        @(posedge clk); #1;
        dbg(2'd3, 8'h77, "hold_written");
        wait_idle("hold");

        issue(16'h0D80);
        check("rst_mid_exec_state", {15'h0, in_ready}, 16'h0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_wb_valid", {15'h0, wb_valid}, 16'h0);
        for (int i = 0; i < 4; i++) dbg(i[1:0], 8'h00, "rst_mid_rf");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_in_ready", {15'h0, in_ready}, 16'h1);
        check("rst_mid_no_wb", {15'h0, wb_valid}, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
